// File: rtl/complex_axis_requantizer_if.sv
// AXI-Stream style beat bundle shared by the requantizer input and output ports.
// A beat moves on a rising edge where tvalid and tready are both 1; tdata/tuser are held while tvalid=1 and tready=0.
interface complex_axis_requantizer_if #(
    parameter int DATA_W = 64,
    parameter int USER_W = 2
);
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tuser, output tvalid, input tready);
    modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface

// File: rtl/complex_axis_requantizer.sv
// Complex sample requantizer: register, round/shift/saturate each component, then buffer in a small FIFO.
// Input readiness is registered from post-edge occupancy so the FIFO can absorb the in-flight stage-1 beat.
module complex_axis_requantizer #(
    parameter int OPERAND_WIDTH_IN  = 32,
    parameter int OPERAND_WIDTH_OUT = 16,
    parameter int SHIFT             = 15,
    parameter int ROUND_MODE        = 0,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    complex_axis_requantizer_if.slave  s_axis,
    complex_axis_requantizer_if.master m_axis,
    output logic                      pad_error
);
    localparam int IN  = OPERAND_WIDTH_IN;
    localparam int OUT = OPERAND_WIDTH_OUT;
    localparam int IW  = ((IN * 2 + 15) / 16) * 16;
    localparam int OW  = ((OUT * 2 + 15) / 16) * 16;
    localparam int IH  = IW / 2;
    localparam int OH  = OW / 2;
    localparam int EW  = IN + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [EW-1:0] RND = (ROUND_MODE == 1 && SHIFT > 0) ? (EW'(1) << RSH) : '0;

    // One extra bit keeps the rounding add from overflowing; result is {sat, value}.
    function automatic logic [OUT:0] requant(input logic [IN-1:0] comp);
        logic signed [EW-1:0]  ext;
        logic signed [EW-1:0]  sum;
        logic signed [EW-1:0]  shd;
        logic signed [OUT-1:0] nar;
        logic                  sat;
        ext = EW'($signed(comp));
        sum = ext + $signed(RND);
        shd = sum >>> SHIFT;
        nar = shd[OUT-1:0];
        sat = (shd != EW'(nar));
        if (sat) begin
            nar = shd[EW-1] ? {1'b1, {(OUT-1){1'b0}}} : {1'b0, {(OUT-1){1'b1}}};
        end
        return {sat, nar};
    endfunction

    logic [IH-1:0] in_re_half, in_im_half;
    logic [IN-1:0] in_re, in_im;
    logic          pad_bad;
    logic          unused_s_tuser;

    assign in_re_half     = s_axis.tdata[IH-1:0];
    assign in_im_half     = s_axis.tdata[IW-1:IH];
    assign in_re          = in_re_half[IN-1:0];
    assign in_im          = in_im_half[IN-1:0];
    assign pad_bad        = (in_re_half != IH'($signed(in_re))) || (in_im_half != IH'($signed(in_im)));
    assign unused_s_tuser = ^s_axis.tuser;

    logic          s1_valid_q, s1_valid_d;
    logic [IN-1:0] s1_re_q, s1_re_d;
    logic [IN-1:0] s1_im_q, s1_im_d;
    logic          s_ready_q, s_ready_d;
    logic          pad_q, pad_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] occ_d;
    logic          s_fire, m_fire, m_valid;

    logic [OUT:0]          re_r, im_r;
    logic signed [OUT-1:0] re_o, im_o;
    logic [OW-1:0]         s2_data;
    logic [1:0]            s2_user;

    assign re_r    = requant(s1_re_q);
    assign im_r    = requant(s1_im_q);
    assign re_o    = re_r[OUT-1:0];
    assign im_o    = im_r[OUT-1:0];
    assign s2_data = {OH'(im_o), OH'(re_o)};
    assign s2_user = {im_r[OUT], re_r[OUT]};

    assign m_valid = (count_q != '0);

    always_comb begin
        s_fire     = s_axis.tvalid & s_ready_q;
        m_fire     = m_valid & m_axis.tready;
        s1_valid_d = s_fire;
        s1_re_d    = s_fire ? in_re : s1_re_q;
        s1_im_d    = s_fire ? in_im : s1_im_q;
        pad_d      = pad_q | (s_fire & pad_bad);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (s1_valid_q) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (m_fire) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({s1_valid_q, m_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Occupancy includes the stage-1 beat, which lands in the FIFO one edge later.
        occ_d     = count_d + CW'(s1_valid_d);
        s_ready_d = (occ_d <= CW'(FIFO_DEPTH - 2));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid_q <= 1'b0;
            s1_re_q    <= '0;
            s1_im_q    <= '0;
            s_ready_q  <= 1'b0;
            pad_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_re_q    <= s1_re_d;
            s1_im_q    <= s1_im_d;
            s_ready_q  <= s_ready_d;
            pad_q      <= pad_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    logic [OW+1:0] mem_q [FIFO_DEPTH];
    logic [OW+1:0] head;

    always_ff @(posedge aclk) begin
        if (s1_valid_q) begin
            mem_q[wr_ptr_q] <= {s2_user, s2_data};
        end
    end

    // Head is gated by valid so an empty (or reset) FIFO presents zeros.
    assign head          = m_valid ? mem_q[rd_ptr_q] : '0;
    assign m_axis.tdata  = head[OW-1:0];
    assign m_axis.tuser  = head[OW+1:OW];
    assign m_axis.tvalid = m_valid;
    assign s_axis.tready = s_ready_q;
    assign pad_error     = pad_q;
endmodule

// File: tb/tb_complex_axis_requantizer.sv
// Directed bench for complex_axis_requantizer: vector table, latency, throughput, backpressure, padding and reset.
module tb_complex_axis_requantizer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [33:0] exp_q[$];

    complex_axis_requantizer_if #(.DATA_W(64), .USER_W(2)) if0_s ();
    complex_axis_requantizer_if #(.DATA_W(32), .USER_W(2)) if0_m ();
    complex_axis_requantizer_if #(.DATA_W(64), .USER_W(2)) if1_s ();
    complex_axis_requantizer_if #(.DATA_W(32), .USER_W(2)) if1_m ();
    complex_axis_requantizer_if #(.DATA_W(48), .USER_W(2)) if2_s ();
    complex_axis_requantizer_if #(.DATA_W(32), .USER_W(2)) if2_m ();
    logic pad0, pad1, pad2;

    complex_axis_requantizer dut0 (.aclk(clk), .aresetn(rst_n), .s_axis(if0_s.slave), .m_axis(if0_m.master), .pad_error(pad0));
    complex_axis_requantizer #(.ROUND_MODE(1)) dut1 (.aclk(clk), .aresetn(rst_n), .s_axis(if1_s.slave), .m_axis(if1_m.master), .pad_error(pad1));
    // 20-bit components leave 4 padding bits in each 24-bit input half.
    complex_axis_requantizer #(.OPERAND_WIDTH_IN(20)) dut2 (.aclk(clk), .aresetn(rst_n), .s_axis(if2_s.slave), .m_axis(if2_m.master), .pad_error(pad2));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard on the default instance: every accepted output beat must match the queue head.
    always @(negedge clk) begin
        if (rst_n && if0_m.tvalid && if0_m.tready) begin
            check("out_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("out_beat", 64'({if0_m.tuser, if0_m.tdata}), 64'(exp_q.pop_front()));
        end
    end

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input logic [63:0] d);
        int n = 0;
        if0_s.tdata  = d;
        if0_s.tvalid = 1'b1;
        while (n < 200) begin
            @(negedge clk);
            if (if0_s.tready) break;
            n++;
        end
        check("send_accept", 64'(n < 200), 64'd1);
        @(posedge clk); #1;
        if0_s.tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); n++;
        end
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_dut1(input logic [63:0] d, input logic [33:0] e, input string nm);
        int n = 0;
        @(posedge clk); #1;
        if1_s.tdata = d; if1_s.tvalid = 1'b1;
        @(posedge clk); #1;
        if1_s.tvalid = 1'b0;
        while (!if1_m.tvalid && n < 10) begin @(negedge clk); n++; end
        check({nm, "_valid"}, 64'(if1_m.tvalid), 64'd1);
        check({nm, "_data"}, 64'({if1_m.tuser, if1_m.tdata}), 64'(e));
        @(posedge clk); #1;
    endtask

    task automatic run_dut2(input logic [47:0] d, input logic [33:0] e, input string nm);
        int n = 0;
        @(posedge clk); #1;
        if2_s.tdata = d; if2_s.tvalid = 1'b1;
        @(posedge clk); #1;
        if2_s.tvalid = 1'b0;
        while (!if2_m.tvalid && n < 10) begin @(negedge clk); n++; end
        check({nm, "_valid"}, 64'(if2_m.tvalid), 64'd1);
        check({nm, "_data"}, 64'({if2_m.tuser, if2_m.tdata}), 64'(e));
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] ramp_beat(input int i);
        return {32'h0, 32'(i) << 15};
    endfunction

    function automatic logic [33:0] ramp_exp(input int i);
        return {2'b00, 16'h0000, 16'(i)};
    endfunction

    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        logic [31:0] exp_data;
        logic [1:0]  exp_user;
    } vec_t;
    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int idx;
        int start;
        vecs[0] = '{32'h00010000, 32'hFFFF0000, 32'hFFFE0002, 2'b00};
        vecs[1] = '{32'h40000000, 32'hC0000000, 32'h80007FFF, 2'b01};
        vecs[2] = '{32'h80000000, 32'h7FFFFFFF, 32'h7FFF8000, 2'b11};
        vecs[3] = '{32'h00004000, 32'hFFFFBFFF, 32'hFFFF0000, 2'b00};
        vecs[4] = '{32'h3FFF8000, 32'hC0000000, 32'h80007FFF, 2'b00};
        vecs[5] = '{32'h3FFFFFFF, 32'hBFFF7FFF, 32'h80007FFF, 2'b10};
        vecs[6] = '{32'hFFFFFFFF, 32'h00007FFF, 32'h0000FFFF, 2'b00};

        rst_n = 1'b0;
        if0_s.tdata = '0; if0_s.tuser = '0; if0_s.tvalid = 1'b0; if0_m.tready = 1'b0;
        if1_s.tdata = '0; if1_s.tuser = '0; if1_s.tvalid = 1'b0; if1_m.tready = 1'b1;
        if2_s.tdata = '0; if2_s.tuser = '0; if2_s.tvalid = 1'b0; if2_m.tready = 1'b1;
        #3;
        check("rst_s_ready", 64'(if0_s.tready), 64'd0);
        check("rst_m_valid", 64'(if0_m.tvalid), 64'd0);
        check("rst_m_data", 64'({if0_m.tuser, if0_m.tdata}), 64'd0);
        check("rst_pad", 64'(pad0), 64'd0);
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 64'(if0_s.tready), 64'd1);

        // Latency: accepted at edge k, visible after edge k+1.
        if0_m.tready = 1'b1;
        @(posedge clk); #1;
        if0_s.tdata = {32'hFFFF0000, 32'h00010000}; if0_s.tvalid = 1'b1;
        exp_q.push_back({2'b00, 32'hFFFE0002});
        @(posedge clk); #1;
        if0_s.tvalid = 1'b0;
        check("lat_edge_k", 64'(if0_m.tvalid), 64'd0);
        @(posedge clk); #1;
        check("lat_edge_k1", 64'(if0_m.tvalid), 64'd1);
        drain();

        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({vecs[i].exp_user, vecs[i].exp_data});
            send_beat({vecs[i].im, vecs[i].re});
        end
        drain();

        // Continuous stream with the sink always ready.
        @(posedge clk); #1;
        start = cyc;
        for (int i = 0; i < 100; i++) begin
            exp_q.push_back(ramp_exp(i + 100));
            send_beat(ramp_beat(i + 100));
        end
        idx = 0;
        while (exp_q.size() != 0 && idx < 50) begin @(posedge clk); #1; idx++; end
        check("stream_cycles_le_102", 64'((cyc - start) <= 102), 64'd1);
        check("stream_all_out", 64'(exp_q.size()), 64'd0);

        // Backpressure: sink stalled for 20 cycles while 8 ramp beats are offered.
        if0_m.tready = 1'b0;
        idx = 0;
        if0_s.tdata = ramp_beat(0); if0_s.tvalid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (if0_s.tready) begin
                exp_q.push_back(ramp_exp(idx));
                idx++;
            end
            @(posedge clk); #1;
            if0_s.tdata = ramp_beat(idx);
        end
        if0_s.tvalid = 1'b0;
        check("bp_accepted", 64'(idx), 64'd3);
        check("bp_ready_low", 64'(if0_s.tready), 64'd0);
        check("bp_head_held", 64'({if0_m.tuser, if0_m.tdata}), 64'(ramp_exp(0)));
        if0_m.tready = 1'b1;
        for (int i = idx; i < 8; i++) begin
            exp_q.push_back(ramp_exp(i));
            send_beat(ramp_beat(i));
        end
        drain();
        check("pad0_clear", 64'(pad0), 64'd0);

        run_dut1({32'hFFFFBFFF, 32'h00004000}, {2'b00, 32'hFFFF0001}, "round_half");
        run_dut1({32'hFFFFC000, 32'h00003FFF}, {2'b00, 32'h00000000}, "round_below");

        check("pad_init", 64'(pad2), 64'd0);
        run_dut2({24'hFFFFFF, 24'h000000}, {2'b00, 32'hFFFF0000}, "pad_good");
        check("pad_clean", 64'(pad2), 64'd0);
        run_dut2({24'h000000, 24'h0FFFFF}, {2'b00, 32'h0000FFFF}, "pad_bad");
        check("pad_set", 64'(pad2), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        check("pad_sticky", 64'(pad2), 64'd1);

        // Mid-stream reset with three beats buffered and the sink stalled.
        if0_m.tready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(ramp_beat(i + 40));
        @(posedge clk); @(posedge clk); #1;
        check("buf_valid", 64'(if0_m.tvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_s_ready", 64'(if0_s.tready), 64'd0);
        check("mid_rst_m_valid", 64'(if0_m.tvalid), 64'd0);
        check("mid_rst_m_data", 64'({if0_m.tuser, if0_m.tdata}), 64'd0);
        check("mid_rst_pad", 64'(pad2), 64'd0);
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_mid_rst", 64'(if0_s.tready), 64'd1);
        if0_m.tready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("no_stale_beats", 64'(if0_m.tvalid), 64'd0);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
